// File: rtl/match_id_queue_pkg.sv
// Shared definitions for the match ID queue.
//   IDX_W  : width of the indexer's bit index (selects one of 32 bits)
//   STAT_W : width of the optional statistics counters
//   id_w() : rule ID width for a given segment width ({seg, idx})
//   stats_t: bundle of the two statistics counters
package match_id_queue_pkg;

  localparam int IDX_W  = 5;
  localparam int STAT_W = 16;

  function automatic int id_w(input int seg_w);
    return seg_w + IDX_W;
  endfunction

  typedef struct packed {
    logic [STAT_W-1:0] ids;
    logic [STAT_W-1:0] stall;
  } stats_t;

endpackage

// File: rtl/match_id_if.sv
// Handshake bundle between the match indexer, the match ID queue and the
// rule-lookup consumer.
//   seg_ld/seg_in      : segment number load (coincident with indexer ld)
//   idx_vld/idx/pse    : indexer output with pause backpressure
//   flush              : synchronous queue clear
//   m_valid/m_ready/m_id : rule ID stream to the consumer
//   idle               : no index pending and queue empty
//   stat_ids/stat_stall: only present with MATCH_ID_QUEUE_STATS_EN
// slave modport = queue side, master modport = environment side.
interface match_id_if #(parameter int SEG_W = 4) ();
  import match_id_queue_pkg::*;

  localparam int ID_W = id_w(SEG_W);

  logic             seg_ld;
  logic [SEG_W-1:0] seg_in;
  logic             idx_vld;
  logic [IDX_W-1:0] idx;
  logic             pse;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [ID_W-1:0]  m_id;
  logic             idle;
`ifdef MATCH_ID_QUEUE_STATS_EN
  logic [STAT_W-1:0] stat_ids;
  logic [STAT_W-1:0] stat_stall;
`endif

  modport slave (
    input  seg_ld, seg_in, idx_vld, idx, flush, m_ready,
    output pse, m_valid, m_id, idle
`ifdef MATCH_ID_QUEUE_STATS_EN
    , output stat_ids, stat_stall
`endif
  );

  modport master (
    output seg_ld, seg_in, idx_vld, idx, flush, m_ready,
    input  pse, m_valid, m_id, idle
`ifdef MATCH_ID_QUEUE_STATS_EN
    , input stat_ids, stat_stall
`endif
  );

endinterface

// File: rtl/match_id_queue_fifo.sv
// match_id_fifo: synchronous FIFO, DEPTH x W, with flush.
//   clk, rst (async, active-high)
//   i_flush : clears pointers/count on the next edge, overrides push/pop
//   i_push  : write i_wdata (caller guarantees !o_full)
//   i_pop   : drop head entry (caller guarantees !o_empty)
//   o_rdata : head entry, read straight from the storage flops
//   o_full, o_empty : derived from the registered occupancy count
module match_id_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  // Storage is reset so the head output is all-zero out of reset and no
  // pre-reset ID can ever reappear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;  // DEPTH is a power of 2: natural wrap
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head slot is never written while non-empty and not full (wr_ptr != rd_ptr),
  // so o_rdata holds steady while the consumer stalls.
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/match_id_queue.sv
// match_id_queue: tags each indexer bit index with the current segment number
// and queues the resulting rule ID for the rule-lookup stage. The indexer is
// paused (pse) while the queue is full so no index is dropped.
//   clk, rst (async, active-high)
//   bus     : match_id_if.slave (segment load, indexer handshake, flush,
//             rule ID stream, idle, optional stats)
// Optional feature: define MATCH_ID_QUEUE_STATS_EN to add the saturating
// stat_ids / stat_stall counters.
module match_id_queue #(
  parameter int SEG_W = 4,
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  match_id_if.slave bus
);
  import match_id_queue_pkg::*;

  localparam int ID_W = id_w(SEG_W);

  logic [SEG_W-1:0] r_seg_q;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [ID_W-1:0]  w_head;

  // An index pushed in the seg_ld cycle still belongs to the previous word,
  // so the push uses the pre-load r_seg_q. Flush leaves the segment alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_seg_q <= '0;
    else if (bus.seg_ld) r_seg_q <= bus.seg_in;
  end

  assign w_push = bus.idx_vld && !w_full && !bus.flush;
  assign w_pop  = !w_empty && bus.m_ready && !bus.flush;

  match_id_fifo #(
    .DEPTH (DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({r_seg_q, bus.idx}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // pse comes only from the registered count, so there is no combinational
  // path from idx_vld back to the indexer.
  assign bus.pse     = w_full;
  assign bus.m_valid = !w_empty;
  assign bus.m_id    = w_head;
  assign bus.idle    = !bus.idx_vld && w_empty;

`ifdef MATCH_ID_QUEUE_STATS_EN
  stats_t r_stats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stats <= '0;
    end else if (bus.flush) begin
      r_stats <= '0;
    end else begin
      if (w_push && (r_stats.ids != '1))
        r_stats.ids <= r_stats.ids + 1'b1;
      if (bus.idx_vld && w_full && (r_stats.stall != '1))
        r_stats.stall <= r_stats.stall + 1'b1;
    end
  end

  assign bus.stat_ids   = r_stats.ids;
  assign bus.stat_stall = r_stats.stall;
`endif

endmodule

// File: tb/tb_match_id_queue.sv
module tb_match_id_queue;
  localparam int SEG_W = 4;
  localparam int DEPTH = 16;
  localparam int ID_W  = SEG_W + 5;

  logic clk;
  logic rst;

  match_id_if #(.SEG_W(SEG_W)) bus ();

  match_id_queue #(.SEG_W(SEG_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (queue of rule IDs) ----------------
  logic [ID_W-1:0]  mq[$];
  logic [SEG_W-1:0] mseg;
  int               mids;
  int               mstall;
  bit               mpush;

  // Applies the rules for one clock edge using the inputs held this cycle.
  task automatic model_update();
    bit full;
    bit valid;
    bit pop;
    if (rst) begin
      mq.delete(); mseg = '0; mids = 0; mstall = 0; mpush = 0;
      return;
    end
    full  = (mq.size() == DEPTH);
    valid = (mq.size() != 0);
    if (bus.flush) begin
      mq.delete(); mids = 0; mstall = 0; mpush = 0;
    end else begin
      mpush = bus.idx_vld && !full;
      pop   = valid && bus.m_ready;
      if (bus.idx_vld && full && mstall < 65535) mstall++;
      if (mpush && mids < 65535) mids++;
      if (pop) void'(mq.pop_front());
      if (mpush) mq.push_back({mseg, bus.idx});
    end
    if (bus.seg_ld) mseg = bus.seg_in;
  endtask

  // ---------------- hand-computed literal expectations ----------------
  bit              lit_id_en;
  logic [ID_W-1:0] lit_id;
  bit              lit_empty_en;
  bit              lit_pse_en;
  bit              lit_pse;
  bit              lit_drain_en;
  bit              lit_stat_en;
  int              lit_ids;
  int              lit_stall;
  int              t3_ptr;

  int n_tot;
  int n_bad;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int esz;
    int ehead;
    if (rst) begin
      esz = 0; ehead = 0;
    end else begin
      esz = mq.size();
      ehead = (esz != 0) ? int'(mq[0]) : 0;
    end
    chk("m_valid", int'(bus.m_valid), int'(esz != 0));
    chk("pse",     int'(bus.pse),     int'(esz == DEPTH));
    chk("idle",    int'(bus.idle),    int'(!bus.idx_vld && esz == 0));
    if (esz != 0 || rst) chk("m_id", int'(bus.m_id), ehead);
    if (lit_id_en) begin
      chk("lit_m_valid", int'(bus.m_valid), 1);
      chk("lit_m_id", int'(bus.m_id), int'(lit_id));
    end
    if (lit_empty_en) begin
      chk("lit_empty_valid", int'(bus.m_valid), 0);
      chk("lit_empty_idle", int'(bus.idle), int'(!bus.idx_vld));
    end
    if (lit_pse_en) chk("lit_pse", int'(bus.pse), int'(lit_pse));
    if (lit_drain_en) begin
      chk("drain_pushed", t3_ptr, 20);
      chk("drain_left", mq.size(), 0);
    end
`ifdef MATCH_ID_QUEUE_STATS_EN
    if (!rst) begin
      chk("stat_ids",   int'(bus.stat_ids),   mids);
      chk("stat_stall", int'(bus.stat_stall), mstall);
    end
    if (lit_stat_en) begin
      chk("lit_stat_ids",   int'(bus.stat_ids),   lit_ids);
      chk("lit_stat_stall", int'(bus.stat_stall), lit_stall);
    end
`endif
  end

  // Inputs and literals for a cycle are set right after the posedge; the
  // compare runs at the negedge; the model then advances across the posedge.
  task automatic step();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #2;
    lit_id_en = 0; lit_empty_en = 0; lit_pse_en = 0;
    lit_drain_en = 0; lit_stat_en = 0;
  endtask

  task automatic drive(input bit ld, input int seg, input bit vld, input int ix,
                       input bit rdy, input bit fl);
    bus.seg_ld  = ld;
    bus.seg_in  = SEG_W'(seg);
    bus.idx_vld = vld;
    bus.idx     = 5'(ix);
    bus.m_ready = rdy;
    bus.flush   = fl;
  endtask

  task automatic expect_id(input int id);
    lit_id_en = 1;
    lit_id    = ID_W'(id);
  endtask

  initial begin
    int k;
    int t3_idx[20];
    n_tot = 0; n_bad = 0; t3_ptr = 0;
    lit_id_en = 0; lit_empty_en = 0; lit_pse_en = 0; lit_pse = 0;
    lit_drain_en = 0; lit_stat_en = 0; lit_ids = 0; lit_stall = 0;
    lit_id = '0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    lit_empty_en = 1;
    step(); step();
    rst = 1'b0;

    // Segment 3, indices 0, 5, 31 -> 0x060, 0x065, 0x07F
    drive(1, 3, 0, 0, 1, 0);       step();
    drive(0, 0, 1, 0, 1, 0);       step();
    drive(0, 0, 1, 5, 1, 0);  expect_id('h060); step();
    drive(0, 0, 1, 31, 1, 0); expect_id('h065); step();
    drive(0, 0, 0, 0, 1, 0);  expect_id('h07F); step();

    // Backpressure: 20 indices with consumer stalled, then drain
    for (int i = 0; i < 20; i++) t3_idx[i] = (i * 7 + 3) % 32;
    drive(1, 5, 0, 0, 1, 0); step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, t3_idx[t3_ptr], 0, 0);
      lit_pse_en = 1;
      lit_pse    = (i >= 16);
      step();
      if (mpush) t3_ptr++;
    end
    k = 0;
    while ((t3_ptr < 20 || mq.size() != 0) && k < 60) begin
      drive(0, 0, t3_ptr < 20, t3_idx[(t3_ptr < 20) ? t3_ptr : 0], 1, 0);
      step();
      if (mpush) t3_ptr++;
      k++;
    end
    drive(0, 0, 0, 0, 1, 0);
    lit_drain_en = 1;
    step();

    // seg_ld in the same cycle as a push uses the old segment
    drive(1, 6, 0, 0, 1, 0); step();
    drive(1, 7, 1, 2, 1, 0); step();
    drive(0, 0, 1, 4, 1, 0); expect_id('h0C2); step();
    drive(0, 0, 0, 0, 1, 0); expect_id('h0E4); step();

    // Flush with 5 queued, overriding push and pop; segment kept
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 10 + i, 0, 0); step();
    end
    drive(0, 0, 1, 20, 1, 1); step();
    drive(0, 0, 0, 0, 1, 0);  lit_empty_en = 1; step();
    drive(0, 0, 1, 1, 1, 0);  step();
    drive(0, 0, 0, 0, 1, 0);  expect_id('h0E1); step();

`ifdef MATCH_ID_QUEUE_STATS_EN
    // 16 pushes and 3 stall cycles after a flush, then flush clears both
    drive(0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 19; i++) begin
      drive(0, 0, 1, i, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0);
    lit_stat_en = 1; lit_ids = 16; lit_stall = 3;
    step();
    drive(0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    lit_stat_en = 1; lit_ids = 0; lit_stall = 0;
    step();
`endif

    // Async reset mid-stream discards everything immediately
    drive(0, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8 + i, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    lit_empty_en = 1;
    step();
    rst = 1'b0;
    lit_empty_en = 1;
    step();
    drive(0, 0, 1, 9, 1, 0); step();
    drive(0, 0, 0, 0, 1, 0); expect_id('h009); step();
    step();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
